// File: rtl/temp_bcd_conv.sv
// DS18B20 raw temperature word to hundredths of a degree C, binary and BCD.
// Clamps to [MIN_RAW, MAX_RAW] and rounds half up, then runs 14 double-dabble steps.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   raw_temp   in   16-bit two's complement, LSB = 1/16 C
//   raw_valid  in   one-cycle strobe qualifying raw_temp
//   busy       out  conversion in progress
//   temp_data  out  magnitude in binary hundredths of a degree C
//   temp_bcd   out  same magnitude as 5 packed BCD digits
//   sign       out  negative temperature (never set for a zero result)
//   range_err  out  last accepted sample was clamped
//   overrun    out  sticky: raw_valid seen while busy
//   out_valid  out  one-cycle strobe marking new outputs
module temp_bcd_conv #(
  parameter logic [15:0] MAX_RAW = 16'h07D0,
  parameter logic [15:0] MIN_RAW = 16'hFC90
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] raw_temp,
  input  logic        raw_valid,
  output logic        busy,
  output logic [19:0] temp_data,
  output logic [19:0] temp_bcd,
  output logic        sign,
  output logic        range_err,
  output logic        overrun,
  output logic        out_valid
);

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [15:0] raw_q;
  logic [13:0] hund_q;
  logic [13:0] bin_q;
  logic [19:0] bcd_q;
  logic [3:0]  cnt;
  logic        neg_q;
  logic        clip_q;

  logic signed [15:0] raw_s;
  logic signed [15:0] clamped;
  logic               over;
  logic               under;
  logic [15:0]        mag;
  logic [15:0]        scaled;
  logic [13:0]        hund;
  logic [33:0]        step;
  logic               accept;
  logic               last;

  // One double-dabble iteration: correct nibbles, then shift {bcd, bin} left.
  function automatic logic [33:0] dd_step(
    input logic [19:0] b,
    input logic [13:0] v
  );
    logic [19:0] a;
    a = b;
    for (int i = 0; i < 5; i++) begin
      if (a[i*4 +: 4] >= 4'd5)
        a[i*4 +: 4] = a[i*4 +: 4] + 4'd3;
    end
    return {a, v} << 1;
  endfunction

  assign accept = (state == IDLE) && raw_valid;
  assign last   = (state == SHIFT) && (cnt == 4'd14);
  assign busy   = (state != IDLE);

  // Clamp and scale; the worst case 2000*25+2 still fits 16 bits.
  always_comb begin
    raw_s   = $signed(raw_q);
    over    = raw_s > $signed(MAX_RAW);
    under   = raw_s < $signed(MIN_RAW);
    clamped = raw_s;
    if (over)
      clamped = $signed(MAX_RAW);
    else if (under)
      clamped = $signed(MIN_RAW);
    mag    = clamped[15] ? 16'(-clamped) : 16'(clamped);
    scaled = mag * 16'd25 + 16'd2;
    hund   = 14'(scaled >> 2);
    step   = dd_step(bcd_q, bin_q);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (raw_valid) state_nxt = LOAD;
      LOAD:    state_nxt = SHIFT;
      SHIFT:   if (cnt == 4'd14) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Working registers; cnt 0..13 are shift steps, 14 is the commit cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      raw_q  <= '0;
      hund_q <= '0;
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt    <= '0;
      neg_q  <= 1'b0;
      clip_q <= 1'b0;
    end else begin
      if (accept)
        raw_q <= raw_temp;
      if (state == LOAD) begin
        hund_q <= hund;
        bin_q  <= hund;
        bcd_q  <= '0;
        cnt    <= '0;
        neg_q  <= clamped[15];
        clip_q <= over | under;
      end else if (state == SHIFT && !last) begin
        bcd_q <= step[33:14];
        bin_q <= step[13:0];
        cnt   <= cnt + 4'd1;
      end
    end
  end

  // Output registers only change on the commit cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      temp_data <= '0;
      temp_bcd  <= '0;
      sign      <= 1'b0;
      range_err <= 1'b0;
      overrun   <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= last;
      if (raw_valid && busy)
        overrun <= 1'b1;
      if (last) begin
        temp_data <= {6'd0, hund_q};
        temp_bcd  <= bcd_q;
        sign      <= neg_q && (hund_q != 14'd0);
        range_err <= clip_q;
      end
    end
  end

endmodule

// File: tb/tb_temp_bcd_conv.sv
// Directed bench for temp_bcd_conv.
// Hand-computed vectors for rounding, clamping, overrun and reset abort.
module tb_temp_bcd_conv;

  logic        clk;
  logic        rst;
  logic [15:0] raw_temp;
  logic        raw_valid;
  logic        busy;
  logic [19:0] temp_data;
  logic [19:0] temp_bcd;
  logic        sign;
  logic        range_err;
  logic        overrun;
  logic        out_valid;

  int checks = 0;
  int fails  = 0;

  temp_bcd_conv dut (
    .clk       (clk),
    .rst       (rst),
    .raw_temp  (raw_temp),
    .raw_valid (raw_valid),
    .busy      (busy),
    .temp_data (temp_data),
    .temp_bcd  (temp_bcd),
    .sign      (sign),
    .range_err (range_err),
    .overrun   (overrun),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulse raw_valid so that it is sampled at the next edge (edge N).
  // Returns 1 time unit after edge N.
  task automatic send(input logic [15:0] r);
    @(posedge clk);
    #1;
    raw_temp  = r;
    raw_valid = 1'b1;
    @(posedge clk);
    #1;
    raw_valid = 1'b0;
  endtask

  // Count edges until out_valid is seen, bounded at 40.
  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic test_reset;
    rst       = 1'b1;
    raw_temp  = '0;
    raw_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_ctl busy=%b ov=%b want 0 0", busy, out_valid);
    end
    checks++;
    if (temp_data !== 20'h0 || temp_bcd !== 20'h0) begin
      fails++;
      $display("FAIL reset_data data=%h bcd=%h want 0 0",
               temp_data, temp_bcd);
    end
    checks++;
    if ({sign, range_err, overrun} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags s/re/ovr=%b want 000",
               {sign, range_err, overrun});
    end
    rst = 1'b0;
  endtask

  task automatic test_basic;
    int lat;
    int busy_bad;
    send(16'h0191);
    busy_bad = busy ? 0 : 1;
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      if (!out_valid && !busy) busy_bad++;
    end
    checks++;
    if (lat !== 16) begin
      fails++;
      $display("FAIL basic_latency got %0d want 16", lat);
    end
    checks++;
    if (busy_bad !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL basic_busy gaps=%0d busy=%b want 0 0",
               busy_bad, busy);
    end
    checks++;
    if (temp_data !== 20'd2506 || temp_bcd !== 20'h02506) begin
      fails++;
      $display("FAIL basic_data data=%0d bcd=%h want 2506 02506",
               temp_data, temp_bcd);
    end
    checks++;
    if (sign !== 1'b0 || range_err !== 1'b0) begin
      fails++;
      $display("FAIL basic_flags s=%b re=%b want 0 0", sign, range_err);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0 || temp_data !== 20'd2506) begin
      fails++;
      $display("FAIL basic_pulse ov=%b data=%0d want 0 2506",
               out_valid, temp_data);
    end
  endtask

  task automatic test_negative;
    int lat;
    send(16'hFF5E);
    wait_done(lat);
    checks++;
    if (lat !== 16 || temp_data !== 20'd1013 || temp_bcd !== 20'h01013) begin
      fails++;
      $display("FAIL neg_data lat=%0d data=%0d bcd=%h want 16 1013 01013",
               lat, temp_data, temp_bcd);
    end
    checks++;
    if (sign !== 1'b1 || range_err !== 1'b0) begin
      fails++;
      $display("FAIL neg_flags s=%b re=%b want 1 0", sign, range_err);
    end
  endtask

  task automatic test_clamp_high;
    int lat;
    send(16'h07D0);
    wait_done(lat);
    checks++;
    if (temp_data !== 20'd12500 || temp_bcd !== 20'h12500 ||
        range_err !== 1'b0 || sign !== 1'b0) begin
      fails++;
      $display("FAIL max_edge data=%0d bcd=%h re=%b s=%b want 12500 12500 0 0",
               temp_data, temp_bcd, range_err, sign);
    end
    send(16'h0800);
    wait_done(lat);
    checks++;
    if (temp_data !== 20'd12500 || temp_bcd !== 20'h12500 ||
        range_err !== 1'b1 || sign !== 1'b0) begin
      fails++;
      $display("FAIL max_clamp data=%0d bcd=%h re=%b s=%b want 12500 12500 1 0",
               temp_data, temp_bcd, range_err, sign);
    end
  endtask

  task automatic test_clamp_low;
    int lat;
    send(16'h8000);
    wait_done(lat);
    checks++;
    if (temp_data !== 20'd5500 || temp_bcd !== 20'h05500) begin
      fails++;
      $display("FAIL min_clamp data=%0d bcd=%h want 5500 05500",
               temp_data, temp_bcd);
    end
    checks++;
    if (sign !== 1'b1 || range_err !== 1'b1) begin
      fails++;
      $display("FAIL min_flags s=%b re=%b want 1 1", sign, range_err);
    end
  endtask

  task automatic test_back_to_back;
    int lat;
    send(16'h0191);
    wait_done(lat);
    checks++;
    if (busy !== 1'b0 || temp_data !== 20'd2506) begin
      fails++;
      $display("FAIL b2b_first busy=%b data=%0d want 0 2506",
               busy, temp_data);
    end
    raw_temp  = 16'hFF5E;
    raw_valid = 1'b1;
    @(posedge clk);
    #1;
    raw_valid = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if (temp_data !== 20'd2506 || temp_bcd !== 20'h02506 ||
        out_valid !== 1'b0) begin
      fails++;
      $display("FAIL b2b_hold data=%0d bcd=%h ov=%b want 2506 02506 0",
               temp_data, temp_bcd, out_valid);
    end
    wait_done(lat);
    checks++;
    if (lat !== 8 || temp_data !== 20'd1013 || sign !== 1'b1) begin
      fails++;
      $display("FAIL b2b_second lat=%0d data=%0d s=%b want 8 1013 1",
               lat, temp_data, sign);
    end
    checks++;
    if (overrun !== 1'b0) begin
      fails++;
      $display("FAIL b2b_overrun got %b want 0", overrun);
    end
  endtask

  task automatic test_overrun;
    int lat;
    int extra;
    send(16'h0191);
    repeat (4) @(posedge clk);
    #1;
    raw_temp  = 16'h0800;
    raw_valid = 1'b1;
    @(posedge clk);
    #1;
    raw_valid = 1'b0;
    checks++;
    if (overrun !== 1'b1) begin
      fails++;
      $display("FAIL ovr_flag got %b want 1", overrun);
    end
    wait_done(lat);
    checks++;
    if (lat !== 11 || temp_data !== 20'd2506 || range_err !== 1'b0) begin
      fails++;
      $display("FAIL ovr_result lat=%0d data=%0d re=%b want 11 2506 0",
               lat, temp_data, range_err);
    end
    extra = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid) extra++;
    end
    checks++;
    if (extra !== 0 || overrun !== 1'b1) begin
      fails++;
      $display("FAIL ovr_after extra_ov=%0d ovr=%b want 0 1", extra, overrun);
    end
  endtask

  task automatic test_reset_mid;
    int lat;
    int extra;
    send(16'h0800);
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || temp_data !== 20'h0 || temp_bcd !== 20'h0 ||
        {sign, range_err, overrun, out_valid} !== 4'b0000) begin
      fails++;
      $display("FAIL rstmid_out busy=%b data=%h bcd=%h flags=%b want 0 0 0 0000",
               busy, temp_data, temp_bcd,
               {sign, range_err, overrun, out_valid});
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    extra = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (out_valid || busy) extra++;
    end
    checks++;
    if (extra !== 0 || temp_data !== 20'h0) begin
      fails++;
      $display("FAIL rstmid_abort activity=%0d data=%h want 0 0",
               extra, temp_data);
    end
    send(16'h0000);
    wait_done(lat);
    checks++;
    if (lat !== 16 || temp_bcd !== 20'h00000 || temp_data !== 20'h0 ||
        sign !== 1'b0 || range_err !== 1'b0) begin
      fails++;
      $display("FAIL rstmid_zero lat=%0d bcd=%h data=%h s=%b re=%b want 16 0 0 0 0",
               lat, temp_bcd, temp_data, sign, range_err);
    end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_negative;
    test_clamp_high;
    test_clamp_low;
    test_back_to_back;
    test_overrun;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
